// File: rtl/register_fifo_pkg.sv
// Shared definitions for the register-based skid FIFO: depth limit, count-width helper
// and the sticky error flag bundle.
package register_fifo_pkg;

   localparam int MAX_DEPTH = 64;

   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular pointer with increment enable that wraps by comparing against MODULUS-1,
// so MODULUS need not be a power of two.
module fifo_wrap_ptr #(
   parameter int MODULUS = 3,
   localparam int PW = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   // Pointer register: clear on reset, advance with explicit wrap on inc
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (inc) begin
         if (ptr == PW'(MODULUS - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/register_fifo_skid_n.sv
// Show-ahead register FIFO: dedicated head register refilled from a DEPTH-1 entry ring.
// Optional sticky overflow/underflow outputs are enabled by REGISTER_FIFO_SKID_ERR_EN.
module register_fifo_skid_n
   import register_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int ALMOST_FULL_THRESH = DEPTH - 1,
   localparam int CW = fifo_cnt_w(DEPTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wrreq,
   input  logic [WIDTH-1:0] data,
   output logic             full,
   output logic             almost_full,
   input  logic             rdreq,
   output logic             empty,
   output logic [WIDTH-1:0] q,
   output logic [CW-1:0]    usedw
`ifdef REGISTER_FIFO_SKID_ERR_EN
   ,
   output logic             overflow_err,
   output logic             underflow_err
`endif
);

   localparam int AD = DEPTH - 1;
   localparam int PW = (AD > 1) ? $clog2(AD) : 1;

   if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("register_fifo_skid_n: DEPTH out of range");
   end

   logic [WIDTH-1:0] mem [AD];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             rd_ok;
   logic             wr_ok;
   logic             head_wr;
   logic             arr_wr;
   logic             head_load;
   logic [CW-1:0]    usedw_next;

   assign rd_ok      = rdreq && !empty;
   assign wr_ok      = wrreq && (!full || rd_ok);
   // The ring is bypassed whenever the write would otherwise become the head next cycle.
   assign head_wr    = wr_ok && (empty || (usedw == CW'(1) && rd_ok));
   assign arr_wr     = wr_ok && !head_wr;
   assign head_load  = rd_ok && (usedw >= CW'(2));
   assign usedw_next = usedw + CW'(wr_ok) - CW'(rd_ok);

   fifo_wrap_ptr #(.MODULUS(AD)) u_wr_ptr (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (arr_wr),
      .ptr     (wr_ptr)
   );

   fifo_wrap_ptr #(.MODULUS(AD)) u_rd_ptr (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (head_load),
      .ptr     (rd_ptr)
   );

   // Ring storage, intentionally not reset
   always_ff @(posedge clock) begin
      if (arr_wr) begin
         mem[wr_ptr] <= data;
      end
   end

   // Head register: direct write or refill from the ring (mutually exclusive)
   always_ff @(posedge clock) begin
      if (head_wr) begin
         q <= data;
      end else if (head_load) begin
         q <= mem[rd_ptr];
      end
   end

   // Occupancy and flags, all derived from the next occupancy
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         usedw       <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         usedw       <= usedw_next;
         empty       <= (usedw_next == CW'(0));
         full        <= (usedw_next == CW'(DEPTH));
         almost_full <= (usedw_next >= CW'(ALMOST_FULL_THRESH));
      end
   end

`ifdef REGISTER_FIFO_SKID_ERR_EN
   fifo_err_t err;
   logic      ovf_ev;
   logic      unf_ev;

   assign ovf_ev = wrreq && full && !rd_ok;
   assign unf_ev = rdreq && empty;

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         err <= '0;
      end else begin
         err.overflow  <= err.overflow  | ovf_ev;
         err.underflow <= err.underflow | unf_ev;
      end
   end

   assign overflow_err  = err.overflow;
   assign underflow_err = err.underflow;

   register_fifo_err_checker u_chk (
      .clock   (clock),
      .reset_n (reset_n),
      .ovf_ev  (ovf_ev),
      .unf_ev  (unf_ev)
   );
`endif

endmodule

`ifdef REGISTER_FIFO_SKID_ERR_EN
// Flags each illegal request in simulation.
module register_fifo_err_checker (
   input logic clock,
   input logic reset_n,
   input logic ovf_ev,
   input logic unf_ev
);
   a_no_overflow:  assert property (@(posedge clock) disable iff (!reset_n) !ovf_ev);
   a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n) !unf_ev);
endmodule
`endif

// File: tb/tb_register_fifo_skid_n.sv
// Bench for register_fifo_skid_n: directed vector table on a DEPTH=4 instance and a
// randomised scoreboard run on a DEPTH=5 instance.
module tb_register_fifo_skid_n;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // DEPTH=4, ALMOST_FULL_THRESH=3 instance
   logic       rst4, wr4, rd4, full4, af4, empty4;
   logic [7:0] d4, q4;
   logic [2:0] usedw4;

   // DEPTH=5, default threshold (4) instance
   logic       rst5, wr5, rd5, full5, af5, empty5;
   logic [7:0] d5, q5;
   logic [2:0] usedw5;

   register_fifo_skid_n #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL_THRESH(3)) dut4 (
      .clock(clock), .reset_n(rst4), .wrreq(wr4), .data(d4), .full(full4),
      .almost_full(af4), .rdreq(rd4), .empty(empty4), .q(q4), .usedw(usedw4)
   );

   register_fifo_skid_n #(.WIDTH(8), .DEPTH(5)) dut5 (
      .clock(clock), .reset_n(rst5), .wrreq(wr5), .data(d5), .full(full5),
      .almost_full(af5), .rdreq(rd5), .empty(empty5), .q(q5), .usedw(usedw5)
   );

   typedef struct {
      logic       rst_n;
      logic       wr;
      logic       rd;
      logic [7:0] d;
      logic [2:0] usedw;
      logic       empty;
      logic       full;
      logic       af;
      logic       chk_q;
      logic [7:0] q;
   } vec_t;

   vec_t tbl[$];
   logic [7:0] sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic [7:0] d,
                               input logic [2:0] u, input logic e, input logic f, input logic a,
                               input logic cq, input logic [7:0] qq);
      vec_t v;
      v.rst_n = r; v.wr = w; v.rd = rd; v.d = d; v.usedw = u;
      v.empty = e; v.full = f; v.af = a; v.chk_q = cq; v.q = qq;
      return v;
   endfunction

   initial begin
      int cnt;
      logic rdok, wrok;

      //              rst wr rd data   usedw emp full af chkq q
      tbl.push_back(mk(1, 1, 0, 8'hA1, 3'd1, 0, 0, 0, 1, 8'hA1));
      tbl.push_back(mk(1, 1, 0, 8'hA2, 3'd2, 0, 0, 0, 1, 8'hA1));
      tbl.push_back(mk(1, 1, 0, 8'hA3, 3'd3, 0, 0, 1, 1, 8'hA1));
      tbl.push_back(mk(1, 1, 0, 8'hA4, 3'd4, 0, 1, 1, 1, 8'hA1));
      tbl.push_back(mk(1, 1, 1, 8'hB5, 3'd4, 0, 1, 1, 1, 8'hA2));
      tbl.push_back(mk(1, 1, 0, 8'hCC, 3'd4, 0, 1, 1, 1, 8'hA2));
      tbl.push_back(mk(1, 0, 1, 8'h00, 3'd3, 0, 0, 1, 1, 8'hA3));
      tbl.push_back(mk(1, 0, 1, 8'h00, 3'd2, 0, 0, 0, 1, 8'hA4));
      tbl.push_back(mk(1, 0, 1, 8'h00, 3'd1, 0, 0, 0, 1, 8'hB5));
      tbl.push_back(mk(1, 0, 1, 8'h00, 3'd0, 1, 0, 0, 0, 8'h00));
      tbl.push_back(mk(1, 0, 1, 8'h00, 3'd0, 1, 0, 0, 0, 8'h00));
      tbl.push_back(mk(1, 1, 1, 8'h11, 3'd1, 0, 0, 0, 1, 8'h11));
      tbl.push_back(mk(1, 0, 1, 8'h00, 3'd0, 1, 0, 0, 0, 8'h00));
      tbl.push_back(mk(1, 1, 0, 8'h01, 3'd1, 0, 0, 0, 1, 8'h01));
      tbl.push_back(mk(1, 1, 0, 8'h02, 3'd2, 0, 0, 0, 1, 8'h01));
      tbl.push_back(mk(1, 1, 0, 8'h03, 3'd3, 0, 0, 1, 1, 8'h01));
      tbl.push_back(mk(0, 1, 0, 8'h55, 3'd0, 1, 0, 0, 0, 8'h00));
      tbl.push_back(mk(1, 1, 0, 8'h77, 3'd1, 0, 0, 0, 1, 8'h77));
      tbl.push_back(mk(1, 1, 1, 8'h88, 3'd1, 0, 0, 0, 1, 8'h88));
      tbl.push_back(mk(1, 0, 1, 8'h00, 3'd0, 1, 0, 0, 0, 8'h00));

      rst4 = 1'b0; wr4 = 1'b0; rd4 = 1'b0; d4 = 8'h00;
      rst5 = 1'b0; wr5 = 1'b0; rd5 = 1'b0; d5 = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      check("rst4_empty", 32'(empty4), 32'd1);
      check("rst4_full",  32'(full4),  32'd0);
      check("rst4_af",    32'(af4),    32'd0);
      check("rst4_usedw", 32'(usedw4), 32'd0);
      check("rst5_empty", 32'(empty5), 32'd1);
      check("rst5_usedw", 32'(usedw5), 32'd0);
      rst5 = 1'b1;

      // Directed vectors on the DEPTH=4 instance
      for (int i = 0; i < tbl.size(); i++) begin
         rst4 = tbl[i].rst_n; wr4 = tbl[i].wr; rd4 = tbl[i].rd; d4 = tbl[i].d;
         @(posedge clock);
         #1;
         check($sformatf("row%0d_usedw", i), 32'(usedw4), 32'(tbl[i].usedw));
         check($sformatf("row%0d_empty", i), 32'(empty4), 32'(tbl[i].empty));
         check($sformatf("row%0d_full", i),  32'(full4),  32'(tbl[i].full));
         check($sformatf("row%0d_af", i),    32'(af4),    32'(tbl[i].af));
         if (tbl[i].chk_q) begin
            check($sformatf("row%0d_q", i), 32'(q4), 32'(tbl[i].q));
         end
      end
      rst4 = 1'b1; wr4 = 1'b0; rd4 = 1'b0;

      // Random traffic on the DEPTH=5 instance against a data scoreboard
      for (int c = 0; c < 10000; c++) begin
         wr5 = 1'($urandom_range(0, 1));
         rd5 = 1'($urandom_range(0, 1));
         d5  = 8'($urandom);
         cnt  = sb.size();
         rdok = rd5 && (cnt != 0);
         wrok = wr5 && ((cnt != 5) || rdok);
         if (rdok) begin
            check("rand_q", 32'(q5), 32'(sb[0]));
            void'(sb.pop_front());
         end
         if (wrok) begin
            sb.push_back(d5);
         end
         @(posedge clock);
         #1;
         cnt = sb.size();
         check("rand_usedw", 32'(usedw5), 32'(cnt));
         check("rand_empty", 32'(empty5), 32'(cnt == 0));
         check("rand_full",  32'(full5),  32'(cnt == 5));
         check("rand_af",    32'(af5),    32'(cnt >= 4));
         if (cnt != 0) begin
            check("rand_head", 32'(q5), 32'(sb[0]));
         end
      end
      wr5 = 1'b0; rd5 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
